// File: rtl/soc_bus_fabric_pkg.sv
// Shared definitions for the data-bus fabric: FSM state encoding, the
// internal MMIO slave's base/mask/word offsets and the default region map.
package soc_bus_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [31:0] MMIO_BASE = 32'hF000_0000;
  localparam logic [31:0] MMIO_MASK = 32'hFFFF_FFF0;

  // MMIO register word index (addr[3:2])
  localparam logic [1:0] MMIO_W_SW     = 2'd0;  // +0x0 switches
  localparam logic [1:0] MMIO_W_REG    = 2'd1;  // +0x4 oREG32
  localparam logic [1:0] MMIO_W_ERRCNT = 2'd2;  // +0x8 error count
  localparam logic [1:0] MMIO_W_ZERO   = 2'd3;  // +0xC reads 0

  // Default 4-slave map, slave i at [i*32 +: 32]: {S3, S2, RAM, ROM}
  localparam logic [127:0] DEF_REGION_BASE = {32'h2000_0000, 32'h1000_0000,
                                              32'h0000_1000, 32'h0000_0000};
  localparam logic [127:0] DEF_REGION_MASK = {32'hFF00_0000, 32'hFFFF_0000,
                                              32'hFFFF_FC00, 32'hFFFF_FC00};

endpackage

// File: rtl/soc_bus_fabric_if.sv
// Bus interface between the CPU data port, the fabric and the slaves.
// Signal names keep the fabric-side port naming (i* = into fabric).
//   slave  : the fabric's view (it is the slave of the CPU data port)
//   master : the view of whatever drives the CPU side and the slave devices
interface soc_bus_fabric_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  logic                      iM_REQ;
  logic                      iM_WR;
  logic [ADDR_W-1:0]         iM_ADDR;
  logic [DATA_W-1:0]         iM_WDATA;
  logic [DATA_W/8-1:0]       iM_BE;
  logic                      oM_ACK;
  logic                      oM_ERR;
  logic [DATA_W-1:0]         oM_RDATA;
  logic [NUM_SLV-1:0]        oS_CE;
  logic                      oS_WR;
  logic [ADDR_W-1:0]         oS_ADDR;
  logic [DATA_W-1:0]         oS_WDATA;
  logic [DATA_W/8-1:0]       oS_BE;
  logic [NUM_SLV-1:0]        iS_ACK;
  logic [NUM_SLV*DATA_W-1:0] iS_RDATA;

  modport slave (
    input  iM_REQ, iM_WR, iM_ADDR, iM_WDATA, iM_BE, iS_ACK, iS_RDATA,
    output oM_ACK, oM_ERR, oM_RDATA, oS_CE, oS_WR, oS_ADDR, oS_WDATA, oS_BE
  );

  modport master (
    output iM_REQ, iM_WR, iM_ADDR, iM_WDATA, iM_BE, iS_ACK, iS_RDATA,
    input  oM_ACK, oM_ERR, oM_RDATA, oS_CE, oS_WR, oS_ADDR, oS_WDATA, oS_BE
  );
endinterface

// File: rtl/soc_fabric_decode.sv
// Combinational address decoder: address -> {hit, one-hot select}.
// Ports: i_addr (address), o_hit (any region matched), o_sel (one-hot).
// Overlapping regions are legal; the lowest index wins.
module soc_fabric_decode #(
  parameter int                        ADDR_W      = 32,
  parameter int                        NUM_SLV     = 4,
  parameter logic [NUM_SLV*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0] REGION_MASK = '0
) (
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               o_hit,
  output logic [NUM_SLV-1:0] o_sel
);

  // Walk from the highest index down so a lower-index match overwrites.
  always_comb begin
    o_hit = 1'b0;
    o_sel = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((i_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        o_sel    = '0;
        o_sel[i] = 1'b1;
        o_hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_bus_fabric.sv
// Data-bus interconnect between the CPU data port and NUM_SLV slaves.
// Latches a request, decodes it, runs a req/ack handshake with the selected
// slave and returns a one-cycle ack with registered read data and error flag.
// Unmapped addresses and slaves that do not ack within TIMEOUT_CYC cycles
// (0 = wait forever) complete with an error.
// Ports:
//   iCLK, iRST_N   clock, asynchronous active-low reset
//   bus            soc_bus_fabric_if.slave (CPU request/response, slave side)
//   iSW, oREG32    switches in / register out (SOC_FABRIC_MMIO_EN only)
// Build option SOC_FABRIC_MMIO_EN adds an internal register slave at
// MMIO_BASE, decoded ahead of all external regions (requires DATA_W >= 32).
//
// state  | meaning
// IDLE   | waiting for iM_REQ; request fields latched on acceptance
// ACCESS | oS_CE asserted to the selected slave, waiting for ack or timeout
// RESP   | oM_ACK pulse with registered oM_ERR/oM_RDATA
module soc_bus_fabric
  import soc_bus_fabric_pkg::*;
#(
  parameter int                        ADDR_W      = 32,
  parameter int                        DATA_W      = 32,
  parameter int                        NUM_SLV     = 4,
  parameter logic [NUM_SLV*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_SLV*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
  parameter int                        TIMEOUT_CYC = 16
) (
  input  logic              iCLK,
  input  logic              iRST_N,
`ifdef SOC_FABRIC_MMIO_EN
  input  logic [7:0]        iSW,
  output logic [31:0]       oREG32,
`endif
  soc_bus_fabric_if.slave   bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  // Timeout fires on the edge where the count would reach TIMEOUT_CYC,
  // so oS_CE stays up for exactly TIMEOUT_CYC cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t             r_state, w_next;
  logic               r_wr;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [BE_W-1:0]    r_be;
  logic [NUM_SLV-1:0] r_sel;
  logic               r_mmio;
  logic               r_err;
  logic [DATA_W-1:0]  r_rdata;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_dec_hit, w_mmio_hit, w_hit, w_accept, w_ack, w_timeout, w_err_resp;
  logic [NUM_SLV-1:0] w_dec_sel, w_sel;
  logic [DATA_W-1:0]  w_slv_rdata, w_mmio_rdata, w_rdata_resp;

  soc_fabric_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_SLV     (NUM_SLV),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decode (
    .i_addr (bus.iM_ADDR),
    .o_hit  (w_dec_hit),
    .o_sel  (w_dec_sel)
  );

`ifdef SOC_FABRIC_MMIO_EN
  assign w_mmio_hit = (bus.iM_ADDR & ADDR_W'(MMIO_MASK)) == ADDR_W'(MMIO_BASE);
`else
  assign w_mmio_hit = 1'b0;
`endif

  assign w_hit      = w_mmio_hit | w_dec_hit;
  assign w_sel      = w_mmio_hit ? '0 : w_dec_sel;
  assign w_accept   = (r_state == ST_IDLE) && bus.iM_REQ;
  // The internal slave always acks in its first ACCESS cycle.
  assign w_ack      = r_mmio | (|(bus.iS_ACK & r_sel));
  assign w_timeout  = (TIMEOUT_CYC != 0) && (r_cnt == CNT_LAST);
  assign w_err_resp = (w_accept && !w_hit) || ((r_state == ST_ACCESS) && !w_ack && w_timeout);

  always_comb begin
    w_slv_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_sel[i]) w_slv_rdata = w_slv_rdata | bus.iS_RDATA[i*DATA_W +: DATA_W];
    end
  end

  assign w_rdata_resp = r_mmio ? w_mmio_rdata : w_slv_rdata;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.iM_REQ) w_next = w_hit ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (w_ack || w_timeout) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Combinational from r_state so an async reset drops oS_CE immediately.
  always_comb begin
    bus.oS_CE  = (r_state == ST_ACCESS) ? r_sel : '0;
    bus.oM_ACK = (r_state == ST_RESP);
  end

  assign bus.oM_ERR   = r_err;
  assign bus.oM_RDATA = r_rdata;
  assign bus.oS_WR    = r_wr;
  assign bus.oS_ADDR  = r_addr;
  assign bus.oS_WDATA = r_wdata;
  assign bus.oS_BE    = r_be;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_sel   <= '0;
      r_mmio  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.iM_REQ) begin
          r_wr    <= bus.iM_WR;
          r_addr  <= bus.iM_ADDR;
          r_wdata <= bus.iM_WDATA;
          r_be    <= bus.iM_BE;
          r_sel   <= w_sel;
          r_mmio  <= w_mmio_hit;
          r_cnt   <= '0;
          r_err   <= !w_hit;
          r_rdata <= '0;
        end
        ST_ACCESS: begin
          if (w_ack) begin
            r_err   <= 1'b0;
            r_rdata <= r_wr ? '0 : w_rdata_resp;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // Response fields only live for the ack cycle.
        ST_RESP: begin
          r_err   <= 1'b0;
          r_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef SOC_FABRIC_MMIO_EN
  logic [31:0] r_reg32;
  logic [31:0] r_errcnt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_reg32  <= '0;
      r_errcnt <= '0;
    end else begin
      if ((r_state == ST_ACCESS) && r_mmio && r_wr) begin
        if (r_addr[3:2] == MMIO_W_REG) begin
          for (int b = 0; b < 4; b++) begin
            if (r_be[b]) r_reg32[8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end
        if (r_addr[3:2] == MMIO_W_ERRCNT) r_errcnt <= '0;
      end
      if (w_err_resp && (r_errcnt != '1)) r_errcnt <= r_errcnt + 32'd1;
    end
  end

  always_comb begin
    w_mmio_rdata = '0;
    case (r_addr[3:2])
      MMIO_W_SW:     w_mmio_rdata = DATA_W'({24'b0, iSW});
      MMIO_W_REG:    w_mmio_rdata = DATA_W'(r_reg32);
      MMIO_W_ERRCNT: w_mmio_rdata = DATA_W'(r_errcnt);
      default:       w_mmio_rdata = '0;
    endcase
  end

  assign oREG32 = r_reg32;
`else
  assign w_mmio_rdata = '0;
`endif

endmodule

// File: tb/tb_soc_bus_fabric.sv
module tb_soc_bus_fabric;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int NUM_SLV     = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int ACK_LIMIT   = 200;

  logic iCLK   = 1'b0;
  logic iRST_N = 1'b0;

  soc_bus_fabric_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV)) bus ();

`ifdef SOC_FABRIC_MMIO_EN
  logic [7:0]  iSW = 8'h00;
  logic [31:0] oREG32;
`endif

  soc_bus_fabric #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .NUM_SLV     (NUM_SLV),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
`ifdef SOC_FABRIC_MMIO_EN
    .iSW    (iSW),
    .oREG32 (oREG32),
`endif
    .bus    (bus)
  );

  always #5 iCLK = ~iCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t sb_q[$];
  string cur_tag = "none";
  int    cyc = 0;
  int    exp_errs = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  // Scoreboard: every ack pops the oldest expected response.
  always @(negedge iCLK) begin
    if (bus.oM_ACK === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk({cur_tag, "_unexpected_ack"}, 64'd1, 64'd0);
      end else begin
        resp_t e;
        e = sb_q.pop_front();
        chk({cur_tag, "_err"},   64'(bus.oM_ERR),   64'(e.err));
        chk({cur_tag, "_rdata"}, 64'(bus.oM_RDATA), 64'(e.rdata));
      end
    end
  end

  // Slave models: slave i acks on CE cycle dly[i] (0 = first, -1 = never).
  int                 dly[NUM_SLV];
  logic [31:0]        srd[NUM_SLV];
  int                 ce_run[NUM_SLV];
  int                 ce_tot[NUM_SLV];
  logic [NUM_SLV-1:0] force_ack = '0;

  always @(negedge iCLK) begin
    logic [NUM_SLV-1:0] a;
    a = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      bus.iS_RDATA[i*32 +: 32] = srd[i];
      if (bus.oS_CE[i] === 1'b1) begin
        a[i] = (ce_run[i] == dly[i]);
        ce_run[i]++;
        ce_tot[i]++;
      end else begin
        ce_run[i] = 0;
      end
    end
    bus.iS_ACK = a | force_ack;
  end

  task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic exp_err, input logic [31:0] exp_rd,
                      input int exp_lat, input int exp_slv, input int exp_ce);
    int    n;
    int    rq;
    int    tot;
    resp_t e;
    for (int i = 0; i < NUM_SLV; i++) ce_tot[i] = 0;
    cur_tag = tag;
    e.err   = exp_err;
    e.rdata = exp_rd;
    sb_q.push_back(e);
    if (exp_err) exp_errs++;
    @(negedge iCLK);
    bus.iM_REQ   = 1'b1;
    bus.iM_WR    = wr;
    bus.iM_ADDR  = addr;
    bus.iM_WDATA = wdata;
    bus.iM_BE    = be;
    @(posedge iCLK);
    #1 rq = cyc;
    n = 0;
    @(negedge iCLK);
    while (bus.oM_ACK !== 1'b1 && n < ACK_LIMIT) begin
      @(negedge iCLK);
      n++;
    end
    bus.iM_REQ = 1'b0;
    if (n >= ACK_LIMIT) begin
      chk({tag, "_ack_seen"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_latency"}, 64'(cyc + 1 - rq), 64'(exp_lat));
      tot = 0;
      for (int i = 0; i < NUM_SLV; i++) tot += ce_tot[i];
      chk({tag, "_ce_total"}, 64'(tot), 64'(exp_ce));
      if (exp_slv >= 0) chk({tag, "_ce_slave"}, 64'(ce_tot[exp_slv]), 64'(exp_ce));
    end
    @(negedge iCLK);
    chk({tag, "_ack_one_cycle"}, 64'(bus.oM_ACK), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iM_REQ   = 1'b0;
    bus.iM_WR    = 1'b0;
    bus.iM_ADDR  = '0;
    bus.iM_WDATA = '0;
    bus.iM_BE    = '0;
    srd[0] = 32'h1234_5678;
    srd[1] = 32'h1111_0001;
    srd[2] = 32'h2222_0002;
    srd[3] = 32'h3333_0003;
    for (int i = 0; i < NUM_SLV; i++) dly[i] = 0;

    repeat (2) @(negedge iCLK);
    chk("rst_ce",     64'(bus.oS_CE),    64'd0);
    chk("rst_ack",    64'(bus.oM_ACK),   64'd0);
    chk("rst_err",    64'(bus.oM_ERR),   64'd0);
    chk("rst_rdata",  64'(bus.oM_RDATA), 64'd0);
    chk("rst_saddr",  64'(bus.oS_ADDR),  64'd0);
    chk("rst_swdata", 64'(bus.oS_WDATA), 64'd0);
    chk("rst_sbe",    64'(bus.oS_BE),    64'd0);
    chk("rst_swr",    64'(bus.oS_WR),    64'd0);
    iRST_N = 1'b1;
    @(negedge iCLK);

    // Read slave 0, first-cycle ack
    dly[0] = 0;
    xact("rd_rom", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 32'h1234_5678, 2, 0, 1);

    // Write slave 1, ack on third CE cycle
    dly[1] = 2;
    xact("wr_ram", 1'b1, 32'h0000_1004, 32'hCAFE_F00D, 4'b0011, 1'b0, 32'h0, 4, 1, 3);
    chk("wr_ram_sbe",    64'(bus.oS_BE),    64'h3);
    chk("wr_ram_swdata", 64'(bus.oS_WDATA), 64'hCAFE_F00D);
    chk("wr_ram_saddr",  64'(bus.oS_ADDR),  64'h0000_1004);
    chk("wr_ram_swr",    64'(bus.oS_WR),    64'd1);

    // Unmapped address and region boundaries
    xact("unmapped",  1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b1, 32'h0, 1, -1, 0);
    xact("rom_top",   1'b0, 32'h0000_03FC, 32'h0, 4'hF, 1'b0, 32'h1234_5678, 2, 0, 1);
    xact("rom_above", 1'b0, 32'h0000_0400, 32'h0, 4'hF, 1'b1, 32'h0, 1, -1, 0);
    dly[1] = 0;
    xact("ram_top",   1'b0, 32'h0000_13FC, 32'h0, 4'hF, 1'b0, 32'h1111_0001, 2, 1, 1);
    dly[2] = 1;
    xact("rd_s2",     1'b0, 32'h1000_0ABC, 32'h0, 4'hF, 1'b0, 32'h2222_0002, 3, 2, 2);

    // Timeout on slave 3 with a stray ack from slave 2
    dly[3]    = -1;
    force_ack = 4'b0100;
    xact("timeout", 1'b0, 32'h2000_0000, 32'h0, 4'hF, 1'b1, 32'h0, TIMEOUT_CYC + 1, 3, TIMEOUT_CYC);
    force_ack = '0;
    dly[3]    = 0;

    // Async reset in the middle of an ACCESS
    cur_tag = "rst_mid";
    dly[1]  = 2;
    @(negedge iCLK);
    bus.iM_REQ   = 1'b1;
    bus.iM_WR    = 1'b1;
    bus.iM_ADDR  = 32'h0000_1004;
    bus.iM_WDATA = 32'hCAFE_F00D;
    bus.iM_BE    = 4'b0011;
    @(posedge iCLK);
    #2;
    chk("rst_mid_ce_before", 64'(bus.oS_CE), 64'b0010);
    iRST_N = 1'b0;
    #1;
    chk("rst_mid_ce",    64'(bus.oS_CE),   64'd0);
    chk("rst_mid_saddr", 64'(bus.oS_ADDR), 64'd0);
    bus.iM_REQ = 1'b0;
    repeat (3) @(negedge iCLK);
    chk("rst_mid_ack", 64'(bus.oM_ACK), 64'd0);
    iRST_N   = 1'b1;
    exp_errs = 0;
    repeat (2) @(negedge iCLK);
    xact("after_rst", 1'b1, 32'h0000_1004, 32'hCAFE_F00D, 4'b0011, 1'b0, 32'h0, 4, 1, 3);

`ifdef SOC_FABRIC_MMIO_EN
    iSW = 8'hA5;
    xact("mmio_sw", 1'b0, 32'hF000_0000, 32'h0, 4'hF, 1'b0, 32'h0000_00A5, 2, -1, 0);
    xact("mmio_wr", 1'b1, 32'hF000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 2, -1, 0);
    chk("mmio_oreg", 64'(oREG32), 64'hDEAD_BEEF);
    xact("mmio_wr_b0", 1'b1, 32'hF000_0004, 32'h0000_0011, 4'b0001, 1'b0, 32'h0, 2, -1, 0);
    chk("mmio_oreg_b0", 64'(oREG32), 64'hDEAD_BE11);
    xact("mmio_rd_reg", 1'b0, 32'hF000_0004, 32'h0, 4'hF, 1'b0, 32'hDEAD_BE11, 2, -1, 0);
    xact("mmio_unmapped", 1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b1, 32'h0, 1, -1, 0);
    xact("mmio_errcnt", 1'b0, 32'hF000_0008, 32'h0, 4'hF, 1'b0, 32'(exp_errs), 2, -1, 0);
    xact("mmio_errclr", 1'b1, 32'hF000_0008, 32'h1234, 4'hF, 1'b0, 32'h0, 2, -1, 0);
    exp_errs = 0;
    xact("mmio_errcnt0", 1'b0, 32'hF000_0008, 32'h0, 4'hF, 1'b0, 32'(exp_errs), 2, -1, 0);
    xact("mmio_zero", 1'b0, 32'hF000_000C, 32'h0, 4'hF, 1'b0, 32'h0, 2, -1, 0);
`else
    xact("mmio_absent", 1'b0, 32'hF000_0000, 32'h0, 4'hF, 1'b1, 32'h0, 1, -1, 0);
`endif

    repeat (2) @(negedge iCLK);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
